// File: rtl/plot_sink.sv
// plot_sink: queues pixel writes from a drawing block in a small FIFO, drains them
// to a framebuffer write port, and sweeps a full-screen clear to colour 0.
// Build option: define PLOT_SINK_CLIP_EN to discard off-screen pixels at the input.
module plot_sink #(
  parameter logic [7:0] X_SCREEN_PIXELS = 8'd160,
  parameter logic [6:0] Y_SCREEN_PIXELS = 7'd120,
  parameter int         DEPTH           = 8
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [7:0]  iX,
  input  logic [6:0]  iY,
  input  logic [2:0]  iColour,
  input  logic        iPlot,
  input  logic        iClear,
  input  logic        iMemReady,
  output logic [14:0] oMemAddr,
  output logic [2:0]  oMemData,
  output logic        oMemWrEn,
  output logic        oFull,
  output logic        oOverflow,
  output logic        oBusy,
  output logic        oClearDone
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [14:0] LAST_ADDR =
    15'(int'(X_SCREEN_PIXELS) * int'(Y_SCREEN_PIXELS) - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR, S_CLEAR_DONE} state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  state_t        state, state_next;
  pixel_t        fifo_mem [DEPTH];
  pixel_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          full_q, overflow_q;
  logic          in_range, push, pop, clear_wr, clear_last;
  logic [14:0]   sweep_q, head_addr;
  logic          wr_en_q;
  logic [14:0]   addr_q;
  logic [2:0]    data_q;

`ifdef PLOT_SINK_CLIP_EN
  assign in_range = (iX < X_SCREEN_PIXELS) && (iY < Y_SCREEN_PIXELS);
`else
  assign in_range = 1'b1;
`endif

  // full_q is registered, so a push that coincides with a pop while full is still dropped.
  assign push       = iPlot && in_range && !full_q;
  assign head       = fifo_mem[rd_ptr];
  assign head_addr  = 15'(head.y) * 15'(X_SCREEN_PIXELS) + 15'(head.x);
  assign count_next = count + CW'(push) - CW'(pop);
  assign clear_last = clear_wr && (sweep_q == LAST_ADDR);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; an incoming push moves IDLE to DRAIN at once to keep first-pixel latency short.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (iClear)                     state_next = S_CLEAR;
        else if (count != '0 || push)   state_next = S_DRAIN;
      end
      S_DRAIN:      if (count == '0 && !push) state_next = S_IDLE;
      S_CLEAR:      if (clear_last)           state_next = S_CLEAR_DONE;
      S_CLEAR_DONE: state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  // Output decode: which write source (if any) owns the port this cycle
  always_comb begin
    pop        = 1'b0;
    clear_wr   = 1'b0;
    oClearDone = 1'b0;
    case (state)
      S_DRAIN:      pop        = iMemReady && (count != '0);
      S_CLEAR:      clear_wr   = iMemReady;
      S_CLEAR_DONE: oClearDone = 1'b1;
      default:      ;
    endcase
  end

  // NOTE: the pixel storage has no reset; pointers and count alone define what is valid.
  always_ff @(posedge iClock) begin
    if (push) fifo_mem[wr_ptr] <= '{x: iX, y: iY, colour: iColour};
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count_next;
      full_q <= (count_next == CW'(DEPTH));
      if (iPlot && in_range && full_q) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset)          sweep_q <= '0;
    else if (clear_last) sweep_q <= '0;
    else if (clear_wr)   sweep_q <= sweep_q + 15'd1;
  end

  // Registered framebuffer port: one strobe per accepted write, cleared the cycle after.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (pop) begin
      wr_en_q <= 1'b1;
      addr_q  <= head_addr;
      data_q  <= head.colour;
    end else if (clear_wr) begin
      wr_en_q <= 1'b1;
      addr_q  <= sweep_q;
      data_q  <= 3'd0;
    end else begin
      wr_en_q <= 1'b0;
    end
  end

  assign oMemWrEn  = wr_en_q;
  assign oMemAddr  = addr_q;
  assign oMemData  = data_q;
  assign oFull     = full_q;
  assign oOverflow = overflow_q;
  assign oBusy     = (state != S_IDLE) || (count != '0);

endmodule

// File: doc/plot_sink.md
PLOT_SINK -- requirements
Module: plot_sink

Interface
REQ-001 Parameter X_SCREEN_PIXELS, default 8'd160, screen width in pixels.
REQ-002 Parameter Y_SCREEN_PIXELS, default 7'd120, screen height in pixels.
REQ-003 Parameter DEPTH, default 8, pixel FIFO entries (power of two, 2..16).
REQ-004 iClock  input  1  single clock; all state updates on its rising edge.
REQ-005 iReset  input  1  asynchronous, active-high reset.
REQ-006 iX  input  8  pixel x coordinate from the drawing block.
REQ-007 iY  input  7  pixel y coordinate from the drawing block.
REQ-008 iColour  input  3  pixel colour.
REQ-009 iPlot  input  1  one pixel write request per cycle high.
REQ-010 iClear  input  1  request full-screen clear to colour 3'd0.
REQ-011 iMemReady  input  1  framebuffer port accepts a write this cycle.
REQ-012 oMemAddr  output  15  framebuffer address.
REQ-013 oMemData  output  3  framebuffer write colour.
REQ-014 oMemWrEn  output  1  framebuffer write strobe, one write per high cycle.
REQ-015 oFull  output  1  FIFO holds DEPTH entries.
REQ-016 oOverflow  output  1  sticky: a pixel was lost to a full FIFO.
REQ-017 oBusy  output  1  high while not in S_IDLE or FIFO non-empty.
REQ-018 oClearDone  output  1  one-cycle pulse when a clear sweep completes.

Function
REQ-019 Push: iPlot high and oFull low SHALL enqueue {iX, iY, iColour}; iPlot with oFull high SHALL drop the pixel and set oOverflow.
REQ-020 oFull SHALL be registered from entry count; a push in the same cycle as a pop while full SHALL still be dropped.
REQ-021 Simultaneous push and pop with FIFO non-full SHALL leave count unchanged; FIFO order SHALL be strictly first-in first-out.
REQ-022 Address SHALL be y*X_SCREEN_PIXELS + x, computed at full 15-bit width without truncation of intermediate product.
REQ-023 FSM states: S_IDLE, S_DRAIN, S_CLEAR, S_CLEAR_DONE.
REQ-024 S_IDLE: iClear high -> S_CLEAR (takes priority over draining); else FIFO non-empty -> S_DRAIN.
REQ-025 S_DRAIN: each cycle with FIFO non-empty and iMemReady high SHALL pop head and register oMemWrEn=1, oMemAddr, oMemData for the next cycle; iMemReady low SHALL pop nothing and drive oMemWrEn=0; FIFO empty without pop -> S_IDLE; iClear in S_DRAIN ignored.
REQ-026 Latency: pixel pushed at edge k into an empty FIFO with iMemReady high SHALL appear on oMemWrEn in the cycle after edge k+1.
REQ-027 S_CLEAR: 15-bit sweep counter from 0; each cycle with iMemReady high SHALL write oMemData=3'd0 at counter address and increment; after address X*Y-1 (19199 default) is written -> S_CLEAR_DONE.
REQ-028 During S_CLEAR the FIFO SHALL continue accepting pushes but SHALL NOT drain.
REQ-029 S_CLEAR_DONE: oClearDone=1 for exactly one cycle, then S_IDLE.
REQ-030 oMemWrEn SHALL be 0 whenever iMemReady was low at the preceding edge.

Reset
REQ-031 iReset high SHALL immediately force: state S_IDLE, FIFO empty, sweep counter 0, oMemWrEn=0, oMemAddr=0, oMemData=0, oFull=0, oOverflow=0, oBusy=0, oClearDone=0.
REQ-032 Reset mid-drain or mid-clear SHALL discard all queued pixels and abandon the sweep; no write strobe SHALL be emitted after reset asserts.
REQ-033 oOverflow SHALL clear only by reset.

Configuration
REQ-034 Macro PLOT_SINK_CLIP_EN: defined -> pushes with iX >= X_SCREEN_PIXELS or iY >= Y_SCREEN_PIXELS SHALL be discarded at the input (not enqueued, oOverflow unaffected); undefined -> all pixels enqueued and address computed per REQ-022 regardless of range.

Verification
REQ-035 Reset, iMemReady=1, single iPlot x=38 y=69 colour=7 -> one oMemWrEn cycle, oMemAddr=11078, oMemData=7, two cycles after push edge.
REQ-036 iMemReady=0, 9 consecutive iPlot pushes (DEPTH=8) -> oFull=1 after 8th, 9th dropped, oOverflow=1; raise iMemReady -> exactly 8 writes in push order.
REQ-037 iClear pulse in S_IDLE, iMemReady=1 -> 19200 writes, addresses 0..19199, data 0, then oClearDone for one cycle.
REQ-038 Assert iReset at sweep address 500 -> oMemWrEn=0 immediately, oBusy=0, next iPlot drains normally.
REQ-039 With PLOT_SINK_CLIP_EN, iPlot x=160 y=10 -> no write, oOverflow stays 0; without it -> write at address 1760.
REQ-040 Toggle iMemReady every cycle while draining 4 pixels -> 4 writes, none in cycles following iMemReady=0, order preserved.
